// File: rtl/uart_line_receiver.sv
// UART line receiver: 8N1 serial bytes are collected into a line buffer until LF.
// Latency: line_valid rises 1 clock after the stop-bit sample; rd_data is 1 clock after rd_addr.
// Backpressure: a held line is frozen until line_ack; bytes arriving meanwhile are dropped and flagged in overflow.
//
// Ports: clk/rst (sync, active-high); uart_rx serial in; rd_addr/rd_data buffer read port;
//        line_valid/line_len/line_ack line handshake; overflow sticky drop flag; frame_err stop-bit pulse.
// Optional feature: define UART_LINE_FRAME_CHECK_EN to reject bytes with a low stop bit.
module uart_line_receiver #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 57600,
  parameter int DEPTH     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     uart_rx,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [7:0]               rd_data,
  output logic                     line_valid,
  output logic [$clog2(DEPTH):0]   line_len,
  input  logic                     line_ack,
  output logic                     overflow,
  output logic                     frame_err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [7:0]    CHAR_CR   = 8'h0D;
  localparam logic [7:0]    CHAR_LF   = 8'h0A;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_done;

  logic            rx_meta, rx_s, rx_prev;
  logic            frame_ok;

  logic [7:0]      mem [DEPTH];
  logic [AW:0]     wr_ptr, wr_ptr_d, ptr_eff;
  logic [AW:0]     line_len_d;
  logic            line_valid_d, overflow_d;
  logic            ack_take, wr_en;

  // Two-flop synchronizer plus one edge-detect flop; all idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_s) state_d = START;
      end
      START: begin
        // Mid-start-bit check; a line already back high was a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          state_d   = IDLE;
          byte_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_LINE_FRAME_CHECK_EN
  assign frame_ok = rx_s;

  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= byte_done & ~rx_s;
  end
`else
  assign frame_ok  = 1'b1;
  assign frame_err = 1'b0;
`endif

  // An ack taking effect this cycle is applied before the completing byte,
  // so that byte sees an empty, unfrozen buffer.
  assign ack_take = line_ack & line_valid;
  assign ptr_eff  = ack_take ? '0 : wr_ptr;

  always_comb begin
    line_valid_d = line_valid & ~line_ack;
    overflow_d   = ack_take ? 1'b0 : overflow;
    wr_ptr_d     = ptr_eff;
    line_len_d   = line_len;
    wr_en        = 1'b0;
    if (byte_done && frame_ok && shift_q != CHAR_CR) begin
      if (line_valid_d) begin
        overflow_d = 1'b1;
      end else if (shift_q == CHAR_LF) begin
        line_valid_d = 1'b1;
        line_len_d   = ptr_eff;
      end else if (ptr_eff < (AW+1)'(DEPTH)) begin
        wr_en    = 1'b1;
        wr_ptr_d = ptr_eff + 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // Buffer storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr_eff[AW-1:0]] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      line_valid <= 1'b0;
      line_len   <= '0;
      overflow   <= 1'b0;
      rd_data    <= '0;
    end else begin
      wr_ptr     <= wr_ptr_d;
      line_valid <= line_valid_d;
      line_len   <= line_len_d;
      overflow   <= overflow_d;
      rd_data    <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_uart_line_receiver.sv
module tb_uart_line_receiver;

  localparam int CLK_FREQ  = 170;
  localparam int BAUD_RATE = 10;
  localparam int DEPTH     = 64;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;

`ifdef UART_LINE_FRAME_CHECK_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic       line_valid;
  logic [6:0] line_len;
  logic       line_ack;
  logic       overflow;
  logic       frame_err;

  uart_line_receiver #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .line_valid(line_valid),
    .line_len  (line_len),
    .line_ack  (line_ack),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Reference model: what the line buffer should hold, derived from byte rules only.
  logic [7:0] m_mem [DEPTH];
  int         m_ptr;
  int         m_len;
  bit         m_valid;
  bit         m_ovf;

  int errors = 0;
  int checks = 0;
  int d_edge = 0;
  int fe_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop_ok, input bit ack);
    if (ack && m_valid) begin
      m_valid = 0;
      m_ptr   = 0;
      m_ovf   = 0;
    end
    if (FC && !stop_ok) return;
    if (b == 8'h0D) return;
    if (m_valid) begin
      m_ovf = 1;
    end else if (b == 8'h0A) begin
      m_valid = 1;
      m_len   = m_ptr;
    end else if (m_ptr < DEPTH) begin
      m_mem[m_ptr] = b;
      m_ptr++;
    end else begin
      m_ovf = 1;
    end
  endtask

  // ack_edge > 0 holds line_ack high across that clock edge counted from the
  // start of the stop bit; meas records the edge after which line_valid rose.
  task automatic send_byte(input logic [7:0] b, input bit stop_bit, input int ack_edge, input bit meas);
    fe_seen = 0;
    uart_rx = 1'b0;
    wait_edges(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_edges(CPB);
    end
    uart_rx = stop_bit;
    line_ack = (ack_edge == 1);
    for (int i = 1; i <= 2 * CPB; i++) begin
      wait_edges(1);
      if (frame_err === 1'b1) fe_seen++;
      if (meas && line_valid === 1'b1 && d_edge == 0) d_edge = i;
      if (i == CPB) uart_rx = 1'b1;
      line_ack = (i == ack_edge - 1);
    end
    line_ack = 1'b0;
    model_byte(b, stop_bit, ack_edge > 0);
    chk($sformatf("frame_err_pulses_%02h", b), fe_seen, (FC && !stop_bit) ? 1 : 0);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1, 0, 1'b0);
  endtask

  task automatic do_ack();
    line_ack = 1'b1;
    wait_edges(1);
    line_ack = 1'b0;
    if (m_valid) begin
      m_valid = 0;
      m_ptr   = 0;
      m_ovf   = 0;
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    chk({tag, "_line_valid"}, line_valid, m_valid);
    chk({tag, "_line_len"}, line_len, m_len);
    chk({tag, "_overflow"}, overflow, m_ovf);
    n = m_valid ? m_len : m_ptr;
    for (int a = 0; a < n; a++) begin
      rd_addr = 6'(a);
      wait_edges(1);
      chk($sformatf("%s_rd_data[%0d]", tag, a), rd_data, m_mem[a]);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_line_valid"}, line_valid, 0);
    chk({tag, "_line_len"}, line_len, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
  endtask

  initial begin
    logic [7:0] b;
    int         n;

    rst      = 1'b1;
    uart_rx  = 1'b1;
    line_ack = 1'b0;
    rd_addr  = '0;
    m_ptr = 0; m_len = 0; m_valid = 0; m_ovf = 0;
    wait_edges(3);
    check_zero("reset");
    rst = 1'b0;
    wait_edges(2);

    // "Linux\n", timing the line end for the later ack-collision steps.
    send_str("Linux");
    send_byte(8'h0A, 1'b1, 0, 1'b1);
    chk("linux_len", line_len, 5);
    check_state("linux");
    chk("line_end_edge_found", d_edge > 0, 1);
    do_ack();
    chk("linux_acked_valid", line_valid, 0);

    // CR discarded; ack with no line held is ignored.
    send_str("ab\r\n");
    check_state("ab_cr");
    do_ack();
    chk("ab_acked_valid", line_valid, 0);
    send_str("a");
    do_ack();
    send_str("\n");
    check_state("ignored_ack");
    do_ack();

    // Overflow past DEPTH, then a frozen-line drop, then ack clears it.
    for (int i = 0; i < 70; i++) send_byte(8'h78, 1'b1, 0, 1'b0);
    send_byte(8'h0A, 1'b1, 0, 1'b0);
    chk("ovf_len64", line_len, 64);
    check_state("ovf");
    send_str("q");
    check_state("frozen");
    do_ack();
    chk("ovf_cleared", overflow, 0);
    send_str("z\n");
    check_state("z_line");

    // A byte completing on the ack edge lands at address 0 of the new line.
    send_byte(8'h6B, 1'b1, d_edge, 1'b0);
    chk("collide_byte_valid", line_valid, 0);
    send_str("\n");
    check_state("collide_byte");
    // An LF on the ack edge gives an empty line.
    send_byte(8'h0A, 1'b1, d_edge, 1'b0);
    check_state("collide_lf");
    do_ack();

    // Short low glitch: no byte, line untouched.
    uart_rx = 1'b0;
    wait_edges(CPB / 4);
    uart_rx = 1'b1;
    wait_edges(2 * CPB);
    check_state("glitch");
    send_str("\n");
    check_state("glitch_then_lf");
    do_ack();

    // Bad stop bit.
    send_byte(8'h41, 1'b0, 0, 1'b0);
    send_str("\n");
    check_state("bad_stop");
    do_ack();

    // Random lines, including occasional CRs.
    for (int l = 0; l < 4; l++) begin
      n = $urandom_range(0, 12);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 7) == 0) b = 8'h0D;
        else b = 8'($urandom_range(32, 126));
        send_byte(b, 1'b1, 0, 1'b0);
      end
      send_str("\n");
      check_state($sformatf("rand%0d", l));
      do_ack();
      chk($sformatf("rand%0d_acked", l), line_valid, 0);
    end

    // Reset during bit 4 of a byte following "ab".
    send_str("ab");
    b = 8'h63;
    uart_rx = 1'b0;
    wait_edges(CPB);
    for (int i = 0; i < 4; i++) begin
      uart_rx = b[i];
      wait_edges(CPB);
    end
    uart_rx = b[4];
    wait_edges(CPB / 2);
    rst = 1'b1;
    uart_rx = 1'b1;
    wait_edges(1);
    check_zero("midbyte_reset");
    rst = 1'b0;
    m_ptr = 0; m_len = 0; m_valid = 0; m_ovf = 0;
    wait_edges(2 * CPB);
    send_str("c\n");
    chk("after_reset_len", line_len, 1);
    check_state("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
